// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the instruction-cache fill path.
package cpu_defs;

  localparam int unsigned LINE_WORDS = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [15:0] LINE_MASK  = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } fill_state_t;

endpackage

// File: rtl/ic_line_asm.sv
// Four-slot word collector for one icache line; the visible line only changes
// when a complete line is committed, so aborted fills never disturb it.
module ic_line_asm
  import cpu_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [1:0]   wr_idx,
  input  logic [31:0]  wr_data,
  input  logic         commit,
  output logic [127:0] line_data
);

  logic [31:0]  slot [LINE_WORDS];
  logic [127:0] merged;

  // The last word is merged on the fly so the line is complete in the same edge.
  always_comb begin
    merged = {slot[3], slot[2], slot[1], slot[0]};
    merged[{wr_idx, 5'b00000} +: 32] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) slot[i] <= '0;
      line_data <= '0;
    end else begin
      if (wr_en) slot[wr_idx] <= wr_data;
      if (commit) line_data <= merged;
    end
  end

endmodule

// File: rtl/ic_fill_responder.sv
// Icache line-fill responder: four in-order word reads per 16-byte line,
// assembled into one 128-bit beat, with abort and drain of late responses.
module ic_fill_responder
  import cpu_defs::*;
#(
  parameter int unsigned MWIDTH   = 16,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [27:0]       ic_req_adr,
  output logic              ic_req_ready,
  input  logic              ic_abort,
  output logic              mem_ren,
  output logic [MWIDTH-1:0] mem_radr,
  input  logic              mem_rdy,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [127:0]      ic_rdat_m_data,
  output logic [15:0]       ic_rdat_m_mask,
  output logic              ic_rdat_m_valid,
  output logic              fill_busy
);

  fill_state_t       state, state_nxt;
  logic [MWIDTH-3:0] line_adr;
  logic [2:0]        issue_cnt, rcv_cnt, outs_cnt, outs_nxt;
  logic              req_acc, issue_acc, rcv_en, rcv_last, slot_wr, line_commit;

  assign ic_req_ready = (state == ST_IDLE) & ~ic_abort & ~rst;
  assign req_acc      = ic_req_valid & ic_req_ready;

  assign mem_ren   = (state == ST_ISSUE) & (issue_cnt < 3'(LINE_WORDS))
                   & (outs_cnt < 3'(MAX_OUTS)) & ~ic_abort;
  // Only the word-in-line field advances, so the address never carries out of the line.
  assign mem_radr  = {line_adr, issue_cnt[1:0]};
  assign issue_acc = mem_ren & mem_rdy;

  assign rcv_en      = mem_rvalid & ((state == ST_ISSUE) | (state == ST_WAIT) | (state == ST_DRAIN));
  assign outs_nxt    = outs_cnt + {2'b00, issue_acc} - {2'b00, rcv_en};
  assign rcv_last    = rcv_en & (rcv_cnt == 3'(LINE_WORDS - 1));
  assign slot_wr     = rcv_en & (state != ST_DRAIN) & ~ic_abort;
  assign line_commit = slot_wr & rcv_last;

  assign ic_rdat_m_valid = (state == ST_RESP);
  assign ic_rdat_m_mask  = ic_rdat_m_valid ? LINE_MASK : '0;
  assign fill_busy       = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_acc) state_nxt = ST_ISSUE;
      ST_ISSUE, ST_WAIT: begin
        if (ic_abort)
          state_nxt = (outs_nxt != '0) ? ST_DRAIN : ST_IDLE;
        else if (rcv_last)
          state_nxt = ST_RESP;
        else if ((state == ST_ISSUE) && issue_acc && (issue_cnt == 3'(LINE_WORDS - 1)))
          state_nxt = ST_WAIT;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      ST_DRAIN: if (outs_nxt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      line_adr  <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      outs_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (req_acc) begin
          line_adr  <= (MWIDTH - 2)'(ic_req_adr);
          issue_cnt <= '0;
          rcv_cnt   <= '0;
          outs_cnt  <= '0;
        end
      end else begin
        outs_cnt <= outs_nxt;
        if (issue_acc) issue_cnt <= issue_cnt + 3'd1;
        if (slot_wr)   rcv_cnt   <= rcv_cnt + 3'd1;
      end
    end
  end

  ic_line_asm u_line_asm (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (slot_wr),
    .wr_idx    (rcv_cnt[1:0]),
    .wr_data   (mem_rdata),
    .commit    (line_commit),
    .line_data (ic_rdat_m_data)
  );

endmodule

// File: tb/tb_ic_fill_responder.sv
// Randomised bench for ic_fill_responder against a line-level reference model.
module tb_ic_fill_responder;

  localparam int MW = 16;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid, ic_req_ready, ic_abort;
  logic [27:0]   ic_req_adr;
  logic          mem_ren, mem_rdy, mem_rvalid;
  logic [MW-1:0] mem_radr;
  logic [31:0]   mem_rdata;
  logic [127:0]  ic_rdat_m_data;
  logic [15:0]   ic_rdat_m_mask;
  logic          ic_rdat_m_valid, fill_busy;

  ic_fill_responder #(.MWIDTH(MW), .MAX_OUTS(MO)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_adr(ic_req_adr), .ic_req_ready(ic_req_ready),
    .ic_abort(ic_abort),
    .mem_ren(mem_ren), .mem_radr(mem_radr), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .ic_rdat_m_data(ic_rdat_m_data), .ic_rdat_m_mask(ic_rdat_m_mask),
    .ic_rdat_m_valid(ic_rdat_m_valid), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image and in-order response pipe
  logic [31:0] mem [0:65535];
  typedef struct { logic [31:0] d; int due; } rsp_t;
  rsp_t mq[$];

  // Reference model: fill phase plus issue/receive bookkeeping
  typedef enum { P_IDLE, P_FILL, P_DRAIN, P_RESP } phase_t;
  phase_t       ph = P_IDLE;
  logic [15:0]  m_waddr = '0;
  int           m_iss = 0, m_rcv = 0, m_outs = 0;
  logic [127:0] m_data = '0;

  logic [27:0] req_q[$];
  int cyc = 0, acc_cyc = 0, resp_cyc = 0, exp_acc_cyc = -1;
  int n_mem_issues = 0, n_dut_valid = 0, n_swallowed = 0, abort_outs = -1;

  int g_rdy_pct = 100, g_alt_rdy = 0, g_lat_lo = 1, g_lat_hi = 1;
  int g_abort_mode = 0, g_stray_pct = 0;

  task automatic cycle();
    logic        exp_ready, exp_ren, rv_now, rv, acc_iss;
    logic [31:0] rd;
    logic [29:0] wide;
    @(posedge clk);
    #1;
    cyc++;
    ic_req_valid = (req_q.size() > 0);
    ic_req_adr   = ic_req_valid ? req_q[0] : 28'($urandom);
    mem_rdy      = (g_alt_rdy != 0) ? (cyc % 2 == 0) : (int'($urandom_range(99)) < g_rdy_pct);
    rv_now       = (mq.size() > 0) && (mq[0].due <= cyc);
    case (g_abort_mode)
      0:       ic_abort = 1'b0;
      1:       ic_abort = (int'($urandom_range(99)) < 4);
      2:       ic_abort = (ph == P_FILL) && (m_iss == 2);
      default: ic_abort = (ph == P_FILL) && (m_rcv == 3) && rv_now;
    endcase
    #1;
    exp_ready = (ph == P_IDLE) && !ic_abort;
    exp_ren   = (ph == P_FILL) && (m_iss < 4) && (m_outs < MO) && !ic_abort;
    check("ready", 128'(ic_req_ready), 128'(exp_ready));
    check("ren", 128'(mem_ren), 128'(exp_ren));
    if (exp_ren) check("radr", 128'(mem_radr), 128'({m_waddr[15:2], 2'(m_iss)}));
    check("valid", 128'(ic_rdat_m_valid), 128'(ph == P_RESP));
    check("mask", 128'(ic_rdat_m_mask), 128'((ph == P_RESP) ? 16'hFFFF : 16'h0000));
    check("data", ic_rdat_m_data, m_data);
    check("busy", 128'(fill_busy), 128'(ph != P_IDLE));
    if (ic_rdat_m_valid) n_dut_valid++;

    // Memory: accept reads, answer in order after the drawn latency
    if (mem_ren && mem_rdy) begin
      mq.push_back('{d: mem[mem_radr], due: cyc + int'($urandom_range(g_lat_hi, g_lat_lo)) - 1});
      n_mem_issues++;
      check("outs_le_max", 128'(mq.size() <= MO), 128'(1));
    end
    rv = 1'b0;
    rd = 32'($urandom);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1;
      rd = mq[0].d;
      mq.delete(0);
    end else if (ph == P_IDLE && mq.size() == 0 && int'($urandom_range(99)) < g_stray_pct) begin
      rv = 1'b1;
    end
    mem_rvalid = rv;
    mem_rdata  = rd;

    acc_iss = exp_ren && mem_rdy;
    case (ph)
      P_IDLE: if (ic_req_valid && !ic_abort) begin
        wide    = {ic_req_adr, 2'b00};
        m_waddr = wide[15:0];
        m_iss = 0; m_rcv = 0; m_outs = 0;
        ph = P_FILL;
        acc_cyc = cyc;
        req_q.delete(0);
        if (exp_acc_cyc >= 0) begin
          check("b2b_accept", 128'(cyc), 128'(exp_acc_cyc));
          exp_acc_cyc = -1;
        end
      end
      P_FILL: begin
        m_outs += int'(acc_iss) - int'(rv);
        if (ic_abort) begin
          abort_outs = m_outs;
          ph = (m_outs > 0) ? P_DRAIN : P_IDLE;
        end else begin
          m_iss += int'(acc_iss);
          if (rv) m_rcv++;
          if (m_rcv == 4) begin
            check("issues_per_line", 128'(m_iss), 128'(4));
            for (int i = 0; i < 4; i++)
              m_data[32*i +: 32] = mem[(m_waddr & 16'hFFFC) | 16'(i)];
            ph = P_RESP;
          end
        end
      end
      P_DRAIN: begin
        if (rv) begin m_outs--; n_swallowed++; end
        if (m_outs == 0) ph = P_IDLE;
      end
      default: begin
        ph = P_IDLE;
        resp_cyc = cyc;
        if (req_q.size() > 0 && g_abort_mode == 0) exp_acc_cyc = cyc + 1;
      end
    endcase
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((req_q.size() != 0 || ph != P_IDLE || mq.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, 128'(n < budget), 128'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 128'(ic_req_ready), 128'(0));
    check({tag, "_ren"},   128'(mem_ren), 128'(0));
    check({tag, "_radr"},  128'(mem_radr), 128'(0));
    check({tag, "_data"},  ic_rdat_m_data, 128'(0));
    check({tag, "_mask"},  128'(ic_rdat_m_mask), 128'(0));
    check({tag, "_valid"}, 128'(ic_rdat_m_valid), 128'(0));
    check({tag, "_busy"},  128'(fill_busy), 128'(0));
  endtask

  logic [127:0] saved;
  int v0, i0, n;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    rst = 1'b1; ic_req_valid = 1'b0; ic_req_adr = '0; ic_abort = 1'b0;
    mem_rdy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1 check_all_zero("por");
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;

    // Single fill, latency 1
    mem[16'h40] = 32'h11111111; mem[16'h41] = 32'h22222222;
    mem[16'h42] = 32'h33333333; mem[16'h43] = 32'h44444444;
    v0 = n_dut_valid;
    req_q.push_back(28'h0000010);
    wait_idle("t2", 100);
    check("t2_data", ic_rdat_m_data, 128'h44444444_33333333_22222222_11111111);
    check("t2_latency", 128'(resp_cyc - acc_cyc), 128'(5));
    check("t2_pulses", 128'(n_dut_valid - v0), 128'(1));

    // Backpressure on alternate cycles, latency 3
    g_alt_rdy = 1; g_lat_lo = 3; g_lat_hi = 3;
    v0 = n_dut_valid; i0 = n_mem_issues;
    req_q.push_back(28'($urandom));
    wait_idle("t3", 200);
    check("t3_issues", 128'(n_mem_issues - i0), 128'(4));
    check("t3_pulses", 128'(n_dut_valid - v0), 128'(1));
    g_alt_rdy = 0;

    // Abort one cycle after the second issue, two reads in flight
    g_lat_lo = 4; g_lat_hi = 4; g_abort_mode = 2;
    v0 = n_dut_valid; n_swallowed = 0; abort_outs = -1;
    req_q.push_back(28'h0001230);
    wait_idle("t4", 100);
    check("t4_abort_outs", 128'(abort_outs), 128'(2));
    check("t4_swallowed", 128'(n_swallowed), 128'(2));
    check("t4_pulses", 128'(n_dut_valid - v0), 128'(0));
    g_abort_mode = 0; g_lat_lo = 1; g_lat_hi = 3;
    v0 = n_dut_valid;
    req_q.push_back(28'h0000020);
    wait_idle("t4b", 100);
    check("t4b_pulses", 128'(n_dut_valid - v0), 128'(1));
    check("t4b_data", ic_rdat_m_data, {mem[16'h83], mem[16'h82], mem[16'h81], mem[16'h80]});

    // Abort on the same cycle as the fourth response
    g_lat_lo = 2; g_lat_hi = 2; g_abort_mode = 3;
    v0 = n_dut_valid; saved = ic_rdat_m_data;
    req_q.push_back(28'h0000777);
    wait_idle("t5", 100);
    cycle();
    check("t5_pulses", 128'(n_dut_valid - v0), 128'(0));
    check("t5_data_kept", ic_rdat_m_data, saved);
    check("t5_idle", 128'(fill_busy), 128'(0));
    g_abort_mode = 0;

    // Stray responses while idle must not touch the line
    g_stray_pct = 100;
    saved = ic_rdat_m_data;
    for (int i = 0; i < 4; i++) cycle();
    check("stray_data_kept", ic_rdat_m_data, saved);
    g_stray_pct = 0;

    // Back-to-back fills wrapping the top of the word address space
    g_lat_lo = 1; g_lat_hi = 2;
    v0 = n_dut_valid;
    req_q.push_back(28'hABC3FFF);
    req_q.push_back(28'h5554000);
    wait_idle("t6", 200);
    check("t6_pulses", 128'(n_dut_valid - v0), 128'(2));
    check("t6_data", ic_rdat_m_data, {mem[16'h3], mem[16'h2], mem[16'h1], mem[16'h0]});

    // Reset in the middle of a fill
    g_lat_lo = 3; g_lat_hi = 3;
    req_q.push_back(28'($urandom));
    n = 0;
    while (!(ph == P_FILL && m_iss >= 2) && n < 50) begin cycle(); n++; end
    check("rst_reach_fill", 128'(n < 50), 128'(1));
    rst = 1'b1;
    #1 check_all_zero("mid_rst");
    mq.delete(); req_q.delete();
    ph = P_IDLE; m_data = '0; exp_acc_cyc = -1;
    ic_req_valid = 1'b0; ic_abort = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    cycle();
    check("rst_ready_after", 128'(ic_req_ready), 128'(1));

    // Randomised traffic with aborts, backpressure and stray responses
    g_rdy_pct = 70; g_lat_lo = 1; g_lat_hi = 5; g_abort_mode = 1; g_stray_pct = 5;
    for (int it = 0; it < 60; it++) begin
      n = int'($urandom_range(4, 1));
      for (int k = 0; k < n; k++) req_q.push_back(28'($urandom));
      wait_idle("rand", 2000);
      for (int k = 0; k < int'($urandom_range(3)); k++) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
